// File: rtl/dram_write_arbiter.sv
// Round-robin owner of the shared DRAM write path (af + wdf FIFOs) for two clients.
// Ownership changes only on whole-burst boundaries: one af command plus WDF_BEATS beats.
module dram_write_arbiter #(
  parameter int MAX_BURSTS = 4,
  parameter int WDF_BEATS  = 2
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         c0_req,
  input  logic [2:0]   c0_af_cmd_din,
  input  logic [30:0]  c0_af_addr_din,
  input  logic         c0_af_wr_en,
  input  logic [127:0] c0_wdf_din,
  input  logic [15:0]  c0_wdf_mask_din,
  input  logic         c0_wdf_wr_en,
  output logic         c0_af_full,
  output logic         c0_wdf_full,
  output logic         c0_grant,

  input  logic         c1_req,
  input  logic [2:0]   c1_af_cmd_din,
  input  logic [30:0]  c1_af_addr_din,
  input  logic         c1_af_wr_en,
  input  logic [127:0] c1_wdf_din,
  input  logic [15:0]  c1_wdf_mask_din,
  input  logic         c1_wdf_wr_en,
  output logic         c1_af_full,
  output logic         c1_wdf_full,
  output logic         c1_grant,

  input  logic         af_full,
  input  logic         wdf_full,
  output logic [2:0]   af_cmd_din,
  output logic [30:0]  af_addr_din,
  output logic         af_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din,
  output logic         wdf_wr_en
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  localparam logic [1:0] BEATS = 2'(WDF_BEATS);
  localparam logic [4:0] CAP   = 5'(MAX_BURSTS);

  logic [1:0]   state, state_next;
  logic         last, last_next;
  logic         af_done, af_done_next;
  logic [1:0]   beat_cnt, beat_next;
  logic [3:0]   burst_cnt, burst_next;

  logic         granted, sel;
  logic         own_req, other_req;
  logic         path_af_full, path_wdf_full;
  logic         sel_af_wr_en, sel_wdf_wr_en;
  logic         af_push, wdf_push;
  logic         burst_done, between_bursts;
  logic [4:0]   burst_inc;
  logic [1:0]   other_state;

  // Decode the owner and steer the owner's request onto the DRAM side; no grant means zeros.
  always_comb begin
    granted       = (state == GRANT0) || (state == GRANT1);
    sel           = (state == GRANT1);
    own_req       = sel ? c1_req : c0_req;
    other_req     = sel ? c0_req : c1_req;
    other_state   = sel ? GRANT0 : GRANT1;
    path_af_full  = af_full | af_done;
    path_wdf_full = wdf_full | (beat_cnt == BEATS);
    sel_af_wr_en  = sel ? c1_af_wr_en : c0_af_wr_en;
    sel_wdf_wr_en = sel ? c1_wdf_wr_en : c0_wdf_wr_en;
    af_push       = granted & sel_af_wr_en & ~path_af_full;
    wdf_push      = granted & sel_wdf_wr_en & ~path_wdf_full;

    c0_grant    = (state == GRANT0);
    c1_grant    = (state == GRANT1);
    c0_af_full  = c0_grant ? path_af_full  : 1'b1;
    c0_wdf_full = c0_grant ? path_wdf_full : 1'b1;
    c1_af_full  = c1_grant ? path_af_full  : 1'b1;
    c1_wdf_full = c1_grant ? path_wdf_full : 1'b1;

    af_wr_en     = af_push;
    wdf_wr_en    = wdf_push;
    af_cmd_din   = granted ? (sel ? c1_af_cmd_din   : c0_af_cmd_din)   : '0;
    af_addr_din  = granted ? (sel ? c1_af_addr_din  : c0_af_addr_din)  : '0;
    wdf_din      = granted ? (sel ? c1_wdf_din      : c0_wdf_din)      : '0;
    wdf_mask_din = granted ? (sel ? c1_wdf_mask_din : c0_wdf_mask_din) : '0;
  end

  // Burst tracking and hand-over; a client that goes quiet between bursts releases the path.
  always_comb begin
    state_next     = state;
    last_next      = last;
    af_done_next   = af_done | af_push;
    beat_next      = beat_cnt + {1'b0, wdf_push};
    burst_next     = burst_cnt;
    burst_inc      = {1'b0, burst_cnt} + 5'd1;
    burst_done     = af_done_next && (beat_next == BEATS) && (af_push || wdf_push);
    between_bursts = !af_done && (beat_cnt == 2'd0) && !af_push && !wdf_push;

    case (state)
      IDLE: begin
        if (c0_req && c1_req) state_next = last ? GRANT0 : GRANT1;
        else if (c0_req)      state_next = GRANT0;
        else if (c1_req)      state_next = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (burst_done) begin
          af_done_next = 1'b0;
          beat_next    = 2'd0;
          last_next    = sel;
          if (other_req && ((burst_inc >= CAP) || !own_req)) begin
            state_next = other_state;
            burst_next = 4'd0;
          end else if (own_req) begin
            burst_next = (burst_inc > CAP) ? CAP[3:0] : burst_inc[3:0];
          end else begin
            state_next = IDLE;
            burst_next = 4'd0;
          end
        end else if (between_bursts && !own_req) begin
          last_next  = sel;
          burst_next = 4'd0;
          state_next = other_req ? other_state : IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        af_done_next = 1'b0;
        beat_next    = 2'd0;
        burst_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      af_done   <= 1'b0;
      beat_cnt  <= 2'd0;
      burst_cnt <= 4'd0;
    end else begin
      state     <= state_next;
      last      <= last_next;
      af_done   <= af_done_next;
      beat_cnt  <= beat_next;
      burst_cnt <= burst_next;
    end
  end

endmodule
